// File: rtl/pcie_pkt_pkg.sv
// Shared symbols, TLP type encoding, FSM states and the header-byte classifier
// for the multi-lane TLP detector.
package pcie_pkt_pkg;

   localparam logic [7:0] K_STP = 8'hFB;
   localparam logic [7:0] K_END = 8'hFD;
   localparam logic [7:0] K_EDB = 8'hFE;
   localparam int NUM_TYPES = 10;

   typedef enum logic [3:0] {
      TLP_MRD, TLP_MWR, TLP_IORD, TLP_IOWR, TLP_CFGRD0, TLP_CFGWR0,
      TLP_CFGRD1, TLP_CFGWR1, TLP_CPL, TLP_CPLD, TLP_UNKNOWN
   } tlp_type_e;

   typedef enum logic [1:0] {IDLE, COLLECT, ERR_SKIP} fsm_e;

   function automatic tlp_type_e classify(input logic [7:0] b);
      logic [2:0] fmt;
      logic [4:0] typ;
      fmt = b[7:5];
      typ = b[4:0];
      classify = TLP_UNKNOWN;
      case (typ)
         5'h00: begin
            if (fmt == 3'b000 || fmt == 3'b001) classify = TLP_MRD;
            else if (fmt == 3'b010 || fmt == 3'b011) classify = TLP_MWR;
         end
         5'h02: begin
            if (fmt == 3'b000) classify = TLP_IORD;
            else if (fmt == 3'b010) classify = TLP_IOWR;
         end
         5'h04: begin
            if (fmt == 3'b000) classify = TLP_CFGRD0;
            else if (fmt == 3'b010) classify = TLP_CFGWR0;
         end
         5'h05: begin
            if (fmt == 3'b000) classify = TLP_CFGRD1;
            else if (fmt == 3'b010) classify = TLP_CFGWR1;
         end
         5'h0A: begin
            if (fmt == 3'b000) classify = TLP_CPL;
            else if (fmt == 3'b010) classify = TLP_CPLD;
         end
         default: ;
      endcase
   endfunction

endpackage

// File: rtl/pcie_tlp_classify.sv
// Combinational Fmt/Type decode of one header byte into a type code and a
// one-hot strobe vector (bit index == type code; unknown gives no bit).
module pcie_tlp_classify
   import pcie_pkt_pkg::*;
(
   input  logic [7:0]           hdr_byte,
   output logic [3:0]           tlp_type,
   output logic [NUM_TYPES-1:0] strobe
);

   tlp_type_e t;

   always_comb begin
      t        = classify(hdr_byte);
      tlp_type = t;
      strobe   = '0;
      if (t != TLP_UNKNOWN) strobe = {{(NUM_TYPES-1){1'b0}}, 1'b1} << t;
   end

endmodule

// File: rtl/pcie_tlp_detector_ml.sv
// Multi-lane TLP framer: packs STP..END bytes, honours EDB nullify, classifies
// the header byte and holds one packet behind valid/ready with saturating stats.
module pcie_tlp_detector_ml
   import pcie_pkt_pkg::*;
#(
   parameter int LANES         = 4,
   parameter int MAX_PKT_BYTES = 20,
   parameter int HDR_OFFSET    = 2,
   parameter int CNT_WIDTH     = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [LANES*8-1:0]                 data_in,
   input  logic [LANES-1:0]                   dataK,
   input  logic                               pkt_ready,
   output logic                               pkt_valid,
   output logic [MAX_PKT_BYTES*8-1:0]         PKT,
   output logic [$clog2(MAX_PKT_BYTES+1)-1:0] pkt_len,
   output logic [3:0]                         pkt_type,
   output logic                               MRd,
   output logic                               MWr,
   output logic                               IORd,
   output logic                               IOWr,
   output logic                               CfgRd0,
   output logic                               CfgWr0,
   output logic                               CfgRd1,
   output logic                               CfgWr1,
   output logic                               Cpl,
   output logic                               Cp1D,
   output logic [CNT_WIDTH-1:0]               PKT_count,
   output logic [CNT_WIDTH-1:0]               drop_count,
   output logic [CNT_WIDTH-1:0]               err_count,
   output logic                               nullified
);

   localparam int LEN_W = $clog2(MAX_PKT_BYTES+1);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_BYTES);
   localparam logic [LEN_W-1:0] HDR_LEN = LEN_W'(HDR_OFFSET);

   fsm_e                              state, st_n;
   logic [MAX_PKT_BYTES-1:0][7:0]     col_buf, buf_n, done_buf;
   logic [LEN_W-1:0]                  col_idx, idx_n, done_len;
   logic                              done, good, stop, nul_n, k_v;
   logic [7:0]                        b_v;
   logic [3:0]                        err_inc;
   logic [3:0]                        cls_type;
   logic [NUM_TYPES-1:0]              cls_strobe, strb;

   function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                    input logic [3:0] inc);
      logic [CNT_WIDTH+4:0] s;
      s = {5'b0, c} + {{(CNT_WIDTH+1){1'b0}}, inc};
      sat_add = (s > {5'b0, {CNT_WIDTH{1'b1}}}) ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
   endfunction

   // Lanes are walked in time order; END/EDB close the beat so later lanes are ignored.
   always_comb begin
      st_n     = state;
      buf_n    = col_buf;
      idx_n    = col_idx;
      done     = 1'b0;
      done_len = '0;
      done_buf = '0;
      nul_n    = 1'b0;
      err_inc  = '0;
      stop     = 1'b0;
      b_v      = '0;
      k_v      = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         b_v = data_in[8*i +: 8];
         k_v = dataK[i];
         if (!stop) begin
            if (k_v && b_v == K_STP) begin
               if (st_n == COLLECT || i == 0) begin
                  if (st_n == COLLECT) err_inc = err_inc + 4'd1;
                  st_n  = COLLECT;
                  buf_n = '0;
                  idx_n = '0;
               end else begin
                  err_inc = err_inc + 4'd1;
               end
            end else begin
               case (st_n)
                  COLLECT: begin
                     if (k_v) begin
                        if (b_v == K_END) begin
                           done     = 1'b1;
                           done_len = idx_n;
                           done_buf = buf_n;
                           st_n     = IDLE;
                           stop     = 1'b1;
                        end else if (b_v == K_EDB) begin
                           nul_n = 1'b1;
                           st_n  = IDLE;
                           stop  = 1'b1;
                        end else begin
                           err_inc = err_inc + 4'd1;
                           st_n    = ERR_SKIP;
                        end
                     end else if (idx_n == MAX_LEN) begin
                        err_inc = err_inc + 4'd1;
                        st_n    = ERR_SKIP;
                     end else begin
                        buf_n[idx_n] = b_v;
                        idx_n        = idx_n + 1'b1;
                     end
                  end
                  ERR_SKIP: begin
                     if (k_v && (b_v == K_END || b_v == K_EDB)) begin
                        st_n = IDLE;
                        stop = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
      // A runt still counts as a framing error even though END closed it cleanly.
      good = done && (done_len > HDR_LEN);
      if (done && !good) err_inc = err_inc + 4'd1;
   end

   pcie_tlp_classify u_cls (
      .hdr_byte (done_buf[HDR_OFFSET]),
      .tlp_type (cls_type),
      .strobe   (cls_strobe)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         col_buf    <= '0;
         col_idx    <= '0;
         pkt_valid  <= 1'b0;
         PKT        <= '0;
         pkt_len    <= '0;
         pkt_type   <= '0;
         strb       <= '0;
         PKT_count  <= '0;
         drop_count <= '0;
         err_count  <= '0;
         nullified  <= 1'b0;
      end else begin
         state     <= st_n;
         col_buf   <= buf_n;
         col_idx   <= idx_n;
         nullified <= nul_n;
         err_count <= sat_add(err_count, err_inc);
         strb      <= '0;
         if (good && (!pkt_valid || pkt_ready)) begin
            pkt_valid <= 1'b1;
            PKT       <= done_buf;
            pkt_len   <= done_len;
            pkt_type  <= cls_type;
            strb      <= cls_strobe;
            PKT_count <= sat_add(PKT_count, 4'd1);
         end else begin
            if (good) drop_count <= sat_add(drop_count, 4'd1);
            if (pkt_valid && pkt_ready) pkt_valid <= 1'b0;
         end
      end
   end

   assign {Cp1D, Cpl, CfgWr1, CfgRd1, CfgWr0, CfgRd0, IOWr, IORd, MWr, MRd} = strb;

endmodule

// File: tb/tb_pcie_tlp_detector_ml.sv
// Bench for pcie_tlp_detector_ml (LANES=4): expected packets are queued as they
// are sent and popped by a negedge monitor when the buffer reports a new load.
module tb_pcie_tlp_detector_ml;
   import pcie_pkt_pkg::*;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [4:0]   len;
      logic [3:0]   typ;
      logic [159:0] data;
   } exp_t;

   logic         clk = 0;
   logic         reset;
   logic [31:0]  data_in;
   logic [3:0]   dataK;
   logic         pkt_ready;
   logic         pkt_valid;
   logic [159:0] PKT;
   logic [4:0]   pkt_len;
   logic [3:0]   pkt_type;
   logic         MRd, MWr, IORd, IOWr, CfgRd0, CfgWr0, CfgRd1, CfgWr1, Cpl, Cp1D;
   logic [3:0]   PKT_count, drop_count, err_count;
   logic         nullified;

   exp_t         sb[$];
   exp_t         e_m;
   int           n_cmp = 0, n_bad = 0, nul_seen = 0;
   logic         pv_prev = 0, rdy_prev = 0;
   logic [9:0]   strobes, exp_strb;

   pcie_tlp_detector_ml dut (
      .clk(clk), .reset(reset), .data_in(data_in), .dataK(dataK), .pkt_ready(pkt_ready),
      .pkt_valid(pkt_valid), .PKT(PKT), .pkt_len(pkt_len), .pkt_type(pkt_type),
      .MRd(MRd), .MWr(MWr), .IORd(IORd), .IOWr(IOWr), .CfgRd0(CfgRd0), .CfgWr0(CfgWr0),
      .CfgRd1(CfgRd1), .CfgWr1(CfgWr1), .Cpl(Cpl), .Cp1D(Cp1D),
      .PKT_count(PKT_count), .drop_count(drop_count), .err_count(err_count),
      .nullified(nullified)
   );

   always #5 clk = ~clk;

   assign strobes = {Cp1D, Cpl, CfgWr1, CfgRd1, CfgWr0, CfgRd0, IOWr, IORd, MWr, MRd};

   // A new load is a rising pkt_valid, or pkt_valid staying high across a handshake.
   always @(negedge clk) begin
      if (reset && pkt_valid && (!pv_prev || rdy_prev)) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pkt: got len %0d type %0d, required no packet", pkt_len, pkt_type);
         end else begin
            e_m = sb.pop_front();
            exp_strb = (e_m.typ == 4'd10) ? 10'd0 : (10'd1 << e_m.typ);
            if (pkt_len !== e_m.len || pkt_type !== e_m.typ || PKT !== e_m.data || strobes !== exp_strb) begin
               n_bad++;
               $display("FAIL pkt_out: got len %0d type %0d strb %b data %h, required len %0d type %0d strb %b data %h",
                        pkt_len, pkt_type, strobes, PKT, e_m.len, e_m.typ, exp_strb, e_m.data);
            end
         end
      end else if (strobes !== 10'd0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL stray_strobe: got %b, required 0", strobes);
      end
      if (nullified) nul_seen++;
      pv_prev  = pkt_valid;
      rdy_prev = pkt_ready;
   end

   task automatic beat(input logic [31:0] d, input logic [3:0] k);
      @(posedge clk); #1;
      data_in = d;
      dataK   = k;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(32'h0, 4'h0);
   endtask

   task automatic mk(output bq_t pl, input int n, input logic [7:0] hdr);
      pl = {};
      for (int i = 0; i < n; i++)
         pl.push_back(i == 0 ? 8'h00 : i == 1 ? 8'h01 : i == 2 ? hdr : 8'($urandom_range(0, 255)));
   endtask

   // Frames a payload as STP on lane 0, bytes in lane order, END in the next free lane.
   task automatic send_tlp(input bq_t pl, input logic [3:0] typ, input bit exp_load);
      logic [7:0] lb[$];
      logic       kb[$];
      exp_t       e;
      lb.push_back(K_STP); kb.push_back(1'b1);
      foreach (pl[i]) begin lb.push_back(pl[i]); kb.push_back(1'b0); end
      lb.push_back(K_END); kb.push_back(1'b1);
      while (lb.size() % 4 != 0) begin lb.push_back(8'h00); kb.push_back(1'b0); end
      if (exp_load) begin
         e.len  = 5'(pl.size());
         e.typ  = typ;
         e.data = '0;
         foreach (pl[i]) e.data[8*i +: 8] = pl[i];
         sb.push_back(e);
      end
      for (int b = 0; b < lb.size(); b += 4)
         beat({lb[b+3], lb[b+2], lb[b+1], lb[b]}, {kb[b+3], kb[b+2], kb[b+1], kb[b]});
   endtask

   task automatic test_reset;
      reset = 0; pkt_ready = 1; data_in = 0; dataK = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (pkt_valid !== 1'b0 || PKT !== '0 || pkt_len !== 5'd0 || pkt_type !== 4'd0) begin
         n_bad++;
         $display("FAIL reset_buf: got v %b len %0d type %0d, required 0", pkt_valid, pkt_len, pkt_type);
      end
      n_cmp++;
      if (PKT_count !== 4'd0 || drop_count !== 4'd0 || err_count !== 4'd0 || nullified !== 1'b0 || strobes !== 10'd0) begin
         n_bad++;
         $display("FAIL reset_cnt: got %0d/%0d/%0d nul %b, required 0", PKT_count, drop_count, err_count, nullified);
      end
      @(posedge clk); #1 reset = 1;
   endtask

   task automatic test_mrd;
      bq_t p;
      p = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
            8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
      send_tlp(p, TLP_MRD, 1);
      idle(3);
      @(negedge clk);
      n_cmp++;
      if (PKT_count !== 4'd1) begin
         n_bad++;
         $display("FAIL mrd_count: got %0d, required 1", PKT_count);
      end
   endtask

   task automatic test_full_drop;
      bq_t p;
      @(posedge clk); #1 pkt_ready = 0;
      mk(p, 8, 8'h4A); send_tlp(p, TLP_CPLD, 1);
      idle(2);
      mk(p, 8, 8'h44); send_tlp(p, TLP_CFGWR0, 0);
      idle(3);
      @(negedge clk);
      n_cmp++;
      if (drop_count !== 4'd1 || PKT_count !== 4'd2) begin
         n_bad++;
         $display("FAIL drop_count: got drop %0d pkt %0d, required 1/2", drop_count, PKT_count);
      end
      n_cmp++;
      if (pkt_valid !== 1'b1 || pkt_type !== 4'(TLP_CPLD) || pkt_len !== 5'd8) begin
         n_bad++;
         $display("FAIL held_buf: got v %b type %0d len %0d, required 1/%0d/8", pkt_valid, pkt_type, pkt_len, TLP_CPLD);
      end
      @(posedge clk); #1 pkt_ready = 1;
      idle(2);
   endtask

   task automatic test_nullify;
      int n0;
      n0 = nul_seen;
      beat(32'h030201FB, 4'b0001);
      beat(32'h07060504, 4'b0000);
      beat(32'h0000FE08, 4'b0010);
      idle(3);
      @(negedge clk);
      n_cmp++;
      if (nul_seen - n0 !== 1) begin
         n_bad++;
         $display("FAIL nullify_pulse: got %0d pulses, required 1", nul_seen - n0);
      end
      n_cmp++;
      if (PKT_count !== 4'd2 || err_count !== 4'd0 || pkt_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL nullify_state: got pkt %0d err %0d v %b, required 2/0/0", PKT_count, err_count, pkt_valid);
      end
   endtask

   task automatic test_overflow;
      bq_t p;
      beat(32'h030201FB, 4'b0001);
      for (int i = 0; i < 5; i++) beat(32'h11223344, 4'b0000);
      beat(32'h0000FD55, 4'b0010);
      idle(3);
      @(negedge clk);
      n_cmp++;
      if (err_count !== 4'd1 || pkt_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL overflow24: got err %0d v %b, required 1/0", err_count, pkt_valid);
      end
      mk(p, 21, 8'h40); send_tlp(p, TLP_MWR, 0);
      idle(3);
      @(negedge clk);
      n_cmp++;
      if (err_count !== 4'd2) begin
         n_bad++;
         $display("FAIL overflow21: got err %0d, required 2", err_count);
      end
      mk(p, 10, 8'h40); send_tlp(p, TLP_MWR, 1);
      mk(p, 20, 8'h02); send_tlp(p, TLP_IORD, 1);
      mk(p, 3, 8'h42);  send_tlp(p, TLP_IOWR, 1);
      idle(3);
      @(negedge clk);
      n_cmp++;
      if (PKT_count !== 4'd5) begin
         n_bad++;
         $display("FAIL post_overflow: got %0d, required 5", PKT_count);
      end
   endtask

   task automatic test_back_to_back;
      bq_t p;
      logic [7:0] hdrs[7] = '{8'h04, 8'h45, 8'h0A, 8'h05, 8'h20, 8'h60, 8'h1F};
      logic [3:0] typs[7] = '{4'd4, 4'd7, 4'd8, 4'd6, 4'd0, 4'd1, 4'd10};
      for (int i = 0; i < 7; i++) begin
         mk(p, 5 + i, hdrs[i]);
         send_tlp(p, typs[i], 1);
      end
      idle(3);
      @(negedge clk);
      n_cmp++;
      if (PKT_count !== 4'd12 || err_count !== 4'd2) begin
         n_bad++;
         $display("FAIL b2b_count: got pkt %0d err %0d, required 12/2", PKT_count, err_count);
      end
   endtask

   task automatic test_mid_reset;
      bq_t p;
      beat(32'h030201FB, 4'b0001);
      beat(32'h07060504, 4'b0000);
      @(posedge clk); #1 reset = 0; data_in = 0; dataK = 0;
      @(posedge clk); #1 reset = 1;
      beat(32'h00FD2211, 4'b0100);
      idle(3);
      @(negedge clk);
      n_cmp++;
      if (pkt_valid !== 1'b0 || PKT_count !== 4'd0 || drop_count !== 4'd0 || err_count !== 4'd0) begin
         n_bad++;
         $display("FAIL mid_reset: got v %b cnt %0d/%0d/%0d, required 0", pkt_valid, PKT_count, drop_count, err_count);
      end
      mk(p, 12, 8'h00); send_tlp(p, TLP_MRD, 1);
      idle(3);
      @(negedge clk);
      n_cmp++;
      if (PKT_count !== 4'd1) begin
         n_bad++;
         $display("FAIL after_reset: got %0d, required 1", PKT_count);
      end
   endtask

   task automatic test_saturate_runt;
      bq_t p;
      for (int i = 0; i < 20; i++) begin
         mk(p, 5, 8'h40);
         send_tlp(p, TLP_MWR, 1);
      end
      idle(3);
      @(negedge clk);
      n_cmp++;
      if (PKT_count !== 4'hF) begin
         n_bad++;
         $display("FAIL pkt_sat: got %0h, required F", PKT_count);
      end
      p = '{8'h00, 8'h01};
      send_tlp(p, TLP_MRD, 0);
      idle(3);
      @(negedge clk);
      n_cmp++;
      if (err_count !== 4'd1 || pkt_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL runt: got err %0d v %b, required 1/0", err_count, pkt_valid);
      end
      beat(32'h00FB0000, 4'b0100);
      idle(3);
      @(negedge clk);
      n_cmp++;
      if (err_count !== 4'd2) begin
         n_bad++;
         $display("FAIL stp_lane2: got err %0d, required 2", err_count);
      end
   endtask

   initial begin
      test_reset();
      test_mrd();
      test_full_drop();
      test_nullify();
      test_overflow();
      test_back_to_back();
      test_mid_reset();
      test_saturate_runt();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
